serial_tx_arbiter: RTL and testbench
====================================

Name: serial_tx_arbiter

Overview:
- Shares one byte-serial transmitter between NUM_REQ packet sources.
- Grants are round-robin and packet-locked: a granted requester keeps the transmitter until it delivers a byte with LAST set.
- Optionally prefixes each packet with a header byte that carries the requester index.
- Sits between producer blocks and the serial transmitter feeding the terminal link, which is the mirror of the serial receive/writer path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HEADER_EN, 1, 1 = send header byte {HEADER_TAG, index} before each packet
HEADER_TAG, 5'b10100, upper 5 bits of the header byte
MAX_PKT, 64, maximum bytes per grant; the grant is forcibly released after this many payload bytes

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
IN_REQ_VALID  in  NUM_REQ  requester i has a byte on its data slice
IN_REQ_DATA  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
IN_REQ_LAST  in  NUM_REQ  byte of requester i is the last byte of its packet
OUT_REQ_READY  out  NUM_REQ  one-cycle accept strobe to the granted requester
OUT_GRANT  out  NUM_REQ  one-hot current owner, 0 when idle
OUT_TX_START  out  1  one-cycle strobe, launches OUT_TX_DATA
OUT_TX_DATA  out  8  byte to transmit, held stable from START until BUSY falls
IN_TX_BUSY  in  1  transmitter busy
OUT_ACTIVE  out  1  a packet is in progress
OUT_FORCED_RELEASE  out  1  one-cycle pulse when MAX_PKT ends a grant

Behaviour:
- Reset (RESET_N low, asynchronous):
  - State IDLE; all outputs 0.
  - Round-robin pointer = index 0 has priority; payload counter = 0.
  - Reset mid-packet abandons the packet. No START is issued after reset deasserts until a fresh arbitration.
- State machine:
  - IDLE:
    - If any VALID: pick the first requester at or after the pointer (wrapping modulo NUM_REQ).
    - Latch its one-hot grant into OUT_GRANT and set OUT_ACTIVE.
    - Go to HDR if HEADER_EN=1, otherwise go to FETCH.
  - HDR:
    - OUT_TX_DATA = {HEADER_TAG, 3-bit index}.
    - Pulse START only if BUSY=0, then go to WAIT_HI. If BUSY=1, stay.
  - FETCH:
    - If granted VALID=1 and BUSY=0: latch the data byte and the LAST flag, pulse READY[grant] and START in the same cycle, increment the counter, and go to WAIT_HI.
    - Otherwise stay; the grant is held while the requester stalls.
  - WAIT_HI: stay until BUSY=1, then go to WAIT_LO.
  - WAIT_LO: stay until BUSY=0, then:
    - After a header byte: go to FETCH.
    - After a payload byte with latched LAST=1: go to RELEASE.
    - After a payload byte with counter == MAX_PKT: go to RELEASE and pulse FORCED_RELEASE.
    - Otherwise: go to FETCH.
  - RELEASE:
    - Pointer = (grant index + 1) mod NUM_REQ.
    - Clear OUT_GRANT, OUT_ACTIVE and the counter; go to IDLE.
    - Minimum one idle cycle between packets.
- Latency: VALID with idle bus → grant next cycle → header START the cycle after that (HEADER_EN=1) → first payload START one cycle after the header's BUSY falls.
- Only one READY bit is ever high, and it is high only on the cycle of its accept. READY never goes to a non-granted requester.
- VALID or data changes on non-granted requesters are ignored. A VALID drop by the owner simply stalls FETCH.
- Simultaneous requests are resolved by the pointer only; there is no fixed priority after the first packet.
- Counter width is clog2(MAX_PKT+1). LAST on byte MAX_PKT is a normal release with no FORCED_RELEASE pulse.

Test Plan:
- Single requester, HEADER_EN=1, requester 2 sends 0x41,0x42 (LAST on 0x42); transmitter model asserts BUSY 1 cycle after START for 10 cycles → TX bytes 0xA2,0x41,0x42; READY[2] pulses exactly twice; GRANT returns to 0; next pointer = 3.
- All four requesting single-byte LAST packets continuously from reset → packet order 0,1,2,3,0; no READY to a non-owner.
- Owner 1 drops VALID for 20 cycles mid-packet while requester 0 is valid → GRANT stays 4'b0010, no START during the gap, packet then completes; requester 0 is served next.
- MAX_PKT=4, requester 3 streams 6 bytes without LAST → after 4 bytes FORCED_RELEASE pulses once; requester 3 is re-granted later with a fresh header.
- BUSY held high at grant time → header START is withheld until BUSY is 0; OUT_TX_DATA stays stable through WAIT_LO.
- RESET_N pulsed low during WAIT_LO of requester 1 → outputs 0 immediately (asynchronously); after release, a new arbitration starts from index 0 with no stray START.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: shares one byte-serial transmitter between NUM_REQ packet
// sources. Grants are round-robin and held for a whole packet. Each packet can
// be preceded by a header byte {HEADER_TAG, index}. MAX_PKT caps the number of
// payload bytes sent under one grant.
//
// Ports:
//   CLK, RESET_N        rising-edge clock, asynchronous active-low reset
//   IN_REQ_VALID/DATA/LAST  per-requester byte stream (byte i at [8i+7:8i])
//   OUT_REQ_READY       one-cycle accept strobe to the granted requester
//   OUT_GRANT           one-hot owner, 0 when idle
//   OUT_TX_START/DATA   launch strobe and byte for the transmitter
//   IN_TX_BUSY          transmitter busy
//   OUT_ACTIVE          a packet is in progress
//   OUT_FORCED_RELEASE  pulse when MAX_PKT ends a grant
module serial_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned HEADER_EN  = 1,
  parameter logic [4:0]  HEADER_TAG = 5'b10100,
  parameter int unsigned MAX_PKT    = 64
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NUM_REQ-1:0]     IN_REQ_VALID,
  input  logic [8*NUM_REQ-1:0]   IN_REQ_DATA,
  input  logic [NUM_REQ-1:0]     IN_REQ_LAST,
  output logic [NUM_REQ-1:0]     OUT_REQ_READY,
  output logic [NUM_REQ-1:0]     OUT_GRANT,
  output logic                   OUT_TX_START,
  output logic [7:0]             OUT_TX_DATA,
  input  logic                   IN_TX_BUSY,
  output logic                   OUT_ACTIVE,
  output logic                   OUT_FORCED_RELEASE
);

  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = SEL_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_PKT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_WAIT_HI, S_WAIT_LO, S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;
  logic               hdr_q, hdr_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               start_q, start_d;
  logic               forced_q, forced_d;
  logic               active_q, active_d;

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  logic             arb_found;
  logic [SEL_W-1:0] arb_idx;
  logic [SUM_W-1:0] arb_sum;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_sum = {1'b0, ptr_q} + SUM_W'(k);
      if (arb_sum >= SUM_W'(NUM_REQ)) arb_sum = arb_sum - SUM_W'(NUM_REQ);
      if (!arb_found && IN_REQ_VALID[arb_sum[SEL_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_sum[SEL_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    last_d   = last_q;
    hdr_d    = hdr_q;
    active_d = active_q;
    ready_d  = '0;
    start_d  = 1'b0;
    forced_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d  = NUM_REQ'(1) << arb_idx;
          idx_d    = arb_idx;
          active_d = 1'b1;
          cnt_d    = '0;
          if (HEADER_EN != 0) begin
            data_d  = {HEADER_TAG, 3'(arb_idx)};
            hdr_d   = 1'b1;
            state_d = S_HDR;
          end else begin
            hdr_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_HDR: begin
        if (!IN_TX_BUSY) begin
          start_d = 1'b1;
          state_d = S_WAIT_HI;
        end
      end
      S_FETCH: begin
        // Accept and launch in one step; the owner simply stalls otherwise.
        if (IN_REQ_VALID[idx_q] && !IN_TX_BUSY) begin
          data_d  = IN_REQ_DATA[{idx_q, 3'b000} +: 8];
          last_d  = IN_REQ_LAST[idx_q];
          ready_d = grant_q;
          start_d = 1'b1;
          cnt_d   = CNT_W'(cnt_q + 1'b1);
          hdr_d   = 1'b0;
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (IN_TX_BUSY) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!IN_TX_BUSY) begin
          if (hdr_q) begin
            state_d = S_FETCH;
          end else if (last_q) begin
            state_d = S_RELEASE;
          end else if (cnt_q == CNT_W'(MAX_PKT)) begin
            forced_d = 1'b1;
            state_d  = S_RELEASE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_RELEASE: begin
        ptr_d    = (idx_q == SEL_W'(NUM_REQ - 1)) ? '0 : SEL_W'(idx_q + 1'b1);
        grant_d  = '0;
        active_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      hdr_q    <= 1'b0;
      ready_q  <= '0;
      start_q  <= 1'b0;
      forced_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      last_q   <= last_d;
      hdr_q    <= hdr_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      forced_q <= forced_d;
      active_q <= active_d;
    end
  end

  assign OUT_REQ_READY      = ready_q;
  assign OUT_GRANT          = grant_q;
  assign OUT_TX_START       = start_q;
  assign OUT_TX_DATA        = data_q;
  assign OUT_ACTIVE         = active_q;
  assign OUT_FORCED_RELEASE = forced_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter (NUM_REQ=4, header on, MAX_PKT=4). Producers and
// a transmitter model drive the DUT; expected transmit bytes go into a queue
// and a negedge monitor pops and compares on every START.
module tb_serial_tx_arbiter;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  always #5 CLK = ~CLK;

  wire  [3:0]  req_valid;
  wire  [31:0] req_data;
  wire  [3:0]  req_last;
  logic [3:0]  ready, grant;
  logic        start, active, forced;
  logic [7:0]  txd;
  logic        busy_m = 1'b0;
  logic        force_busy = 1'b0;
  wire         tx_busy = busy_m | force_busy;

  serial_tx_arbiter #(
    .NUM_REQ(4), .HEADER_EN(1), .HEADER_TAG(5'b10100), .MAX_PKT(4)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IN_REQ_VALID(req_valid), .IN_REQ_DATA(req_data), .IN_REQ_LAST(req_last),
    .OUT_REQ_READY(ready), .OUT_GRANT(grant),
    .OUT_TX_START(start), .OUT_TX_DATA(txd), .IN_TX_BUSY(tx_busy),
    .OUT_ACTIVE(active), .OUT_FORCED_RELEASE(forced)
  );

  // Producer byte stores: {last, data}, read index advanced on READY.
  logic [8:0] src_mem [4][64];
  logic [5:0] src_wr [4];
  logic [5:0] src_rd [4];

  for (genvar g = 0; g < 4; g++) begin : g_src
    assign req_valid[g]       = (src_rd[g] < src_wr[g]);
    assign req_data[8*g +: 8] = src_mem[g][src_rd[g]][7:0];
    assign req_last[g]        = src_mem[g][src_rd[g]][8];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];
  int ready_cnt [4];
  int start_cnt  = 0;
  int forced_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    src_mem[r][src_wr[r]] = {l, b};
    src_wr[r] = src_wr[r] + 6'd1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_wr[i] = '0;
      src_rd[i] = '0;
      ready_cnt[i] = 0;
    end
  end

  // Producer side: a READY pulse consumes the current byte.
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++)
      if (RESET_N && ready[i]) src_rd[i] = src_rd[i] + 6'd1;
  end

  // Transmitter model: BUSY rises one cycle after START, lasts 10 cycles.
  logic tx_pend = 1'b0;
  int   tx_left = 0;
  always @(negedge CLK) if (RESET_N && start) tx_pend = 1'b1;
  always @(posedge CLK) begin
    #1;
    if (tx_pend) begin
      busy_m  = 1'b1;
      tx_left = 10;
      tx_pend = 1'b0;
    end else if (busy_m) begin
      tx_left--;
      if (tx_left == 0) busy_m = 1'b0;
    end
  end

  // Monitor: scoreboard on START, data hold window, READY legality.
  logic       chk_on = 1'b0;
  logic       saw_busy = 1'b0;
  logic [7:0] chk_data = 8'h00;
  logic [7:0] exp_b;
  always @(negedge CLK) begin
    if (!RESET_N) begin
      chk_on = 1'b0;
    end else begin
      if (start) begin
        start_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_byte: unexpected START with data %h", txd);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_byte", 32'(txd), 32'(exp_b));
        end
        check("grant_onehot_at_start", 32'($onehot(grant)), 32'd1);
        chk_on = 1'b1;
        chk_data = txd;
        saw_busy = 1'b0;
      end else if (chk_on) begin
        if (tx_busy) saw_busy = 1'b1;
        if (saw_busy && !tx_busy) chk_on = 1'b0;
        else check("tx_data_hold", 32'(txd), 32'(chk_data));
      end
      if (|ready) begin
        check("ready_onehot", 32'($onehot(ready)), 32'd1);
        check("ready_to_owner_only", 32'(ready & ~grant), 32'd0);
        for (int i = 0; i < 4; i++) if (ready[i]) ready_cnt[i]++;
      end
      if (forced) forced_cnt++;
    end
  end

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    repeat (3) @(negedge CLK);
    while ((exp_q.size() != 0 || active) && c < 3000) begin
      @(negedge CLK);
      c++;
    end
    check({"drain_", name}, 32'(c >= 3000), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    int s0, f0, r1, c;
    logic gap_ok;

    #2 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {ready, grant, start, active, forced, txd, 11'd0}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Single requester 2, header + two bytes.
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    wait_drain("single_req2");
    check("req2_ready_count", 32'(ready_cnt[2]), 32'd2);
    check("others_ready_count", 32'(ready_cnt[0] + ready_cnt[1] + ready_cnt[3]), 32'd0);
    check("grant_idle_after_pkt", 32'(grant), 32'd0);

    // Pointer now at 3: requester 3 beats requester 0.
    push(0, 8'h30, 1'b1); push(3, 8'h33, 1'b1);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h33);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h30);
    wait_drain("ptr_after_req2");

    // All four continuously from reset: 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 8'(8'h10 + i), 1'b1);
    for (int i = 0; i < 4; i++) push(i, 8'(8'h20 + i), 1'b1);
    for (int i = 0; i < 4; i++) begin exp_q.push_back(8'(8'hA0 + i)); exp_q.push_back(8'(8'h10 + i)); end
    for (int i = 0; i < 4; i++) begin exp_q.push_back(8'(8'hA0 + i)); exp_q.push_back(8'(8'h20 + i)); end
    wait_drain("round_robin_all");

    // Owner 1 stalls mid-packet while requester 0 waits.
    push(0, 8'h5F, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h5F);
    wait_drain("ptr_to_1");
    r1 = ready_cnt[1];
    push(1, 8'h51, 1'b0); push(0, 8'h60, 1'b1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h51);
    c = 0;
    while (ready_cnt[1] == r1 && c < 2000) begin @(negedge CLK); c++; end
    check("stall_first_accept_timeout", 32'(c >= 2000), 32'd0);
    s0 = start_cnt;
    gap_ok = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (grant !== 4'b0010) gap_ok = 1'b0;
    end
    check("stall_grant_held", 32'(gap_ok), 32'd1);
    check("stall_no_start", 32'(start_cnt), 32'(s0));
    push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
    exp_q.push_back(8'h52); exp_q.push_back(8'h53);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h60);
    wait_drain("stall_resume");

    // MAX_PKT=4: forced release after 4 bytes, fresh header on re-grant.
    f0 = forced_cnt;
    for (int i = 1; i <= 6; i++) push(3, 8'(8'h70 + i), 1'b0);
    exp_q.push_back(8'hA3);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(8'h70 + i));
    exp_q.push_back(8'hA3); exp_q.push_back(8'h75); exp_q.push_back(8'h76);
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin @(negedge CLK); c++; end
    check("maxpkt_stream_timeout", 32'(c >= 3000), 32'd0);
    repeat (15) @(negedge CLK);
    check("maxpkt_regrant_holds", 32'(grant), 32'b1000);
    push(3, 8'h77, 1'b1);
    exp_q.push_back(8'h77);
    wait_drain("maxpkt_tail");
    check("forced_once", 32'(forced_cnt), 32'(f0 + 1));

    // LAST on byte MAX_PKT is a normal release.
    push(2, 8'h81, 1'b0); push(2, 8'h82, 1'b0); push(2, 8'h83, 1'b0); push(2, 8'h84, 1'b1);
    exp_q.push_back(8'hA2);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(8'h80 + i));
    wait_drain("last_at_max");
    check("no_forced_on_last_at_max", 32'(forced_cnt), 32'(f0 + 1));

    // BUSY high at grant: header withheld; pointer wraps from 3 to 0.
    force_busy = 1'b1;
    push(0, 8'h90, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h90);
    s0 = start_cnt;
    repeat (8) @(negedge CLK);
    check("busy_hold_grant", 32'(grant), 32'b0001);
    check("busy_hold_no_start", 32'(start_cnt), 32'(s0));
    check("busy_hold_hdr_data", 32'(txd), 32'hA0);
    force_busy = 1'b0;
    wait_drain("busy_release");

    // Reset during WAIT_LO of requester 1's header.
    push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1);
    exp_q.push_back(8'hA1);
    s0 = start_cnt;
    c = 0;
    while (start_cnt == s0 && c < 2000) begin @(negedge CLK); c++; end
    while (!tx_busy && c < 2000) begin @(negedge CLK); c++; end
    check("pre_reset_wait_timeout", 32'(c >= 2000), 32'd0);
    repeat (2) @(negedge CLK);
    check("pre_reset_grant", 32'(grant), 32'b0010);
    RESET_N = 1'b0;
    #1;
    check("async_reset_outputs", {ready, grant, start, active, forced, txd, 11'd0}, 32'd0);
    push(0, 8'hC0, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hC0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    wait_drain("after_reset");
    check("final_grant_idle", 32'(grant), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d bytes still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
